key_debouncer: RTL



---
 rtl/tow_pkg.sv | 15 +
 rtl/sync_ff.sv | 27 ++
 rtl/key_debouncer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war pin-conditioning blocks.
package tow_pkg;

   // Debouncer qualification states.
   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } debounce_state_t;

   // 20 ms stability window at 50 MHz; used for STABLE_CYCLES on the board build.
   localparam int unsigned DEBOUNCE_CYCLES_HW = 1_000_000;

endpackage : tow_pkg

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer for asynchronous board pins.
// Synchronous active-low reset loads every stage with RESET_VAL so the
// output restarts from a known level.
module sync_ff #(
   parameter int unsigned N         = 2,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_d,
   output logic o_q
);

   logic [N-1:0] r_stages;

   // Shift the raw pin through N flops; the last stage is the safe copy.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_stages <= {N{RESET_VAL}};
      end else begin
         r_stages <= {r_stages[N-2:0], i_d};
      end
   end

   assign o_q = r_stages[N-1];

endmodule : sync_ff

// File: rtl/key_debouncer.sv
// Debounces one player key into a clean "pressed" level.
//
//  state        | meaning
//  -------------+-----------------------------------------------------
//  RELEASED     | key considered up, waiting for a pushed sample
//  PRESS_WAIT   | pushed level seen, counting stable pushed samples
//  PRESSED      | key considered down, waiting for a released sample
//  RELEASE_WAIT | released level seen, counting stable released samples
//
// pressed/busy are registered and decoded from the state being entered,
// so they change on the same edge as the state itself.
module key_debouncer
   import tow_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter bit          ACTIVE_LOW_IN = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic key_raw,
   output logic pressed,
   output logic busy
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
   // cnt+1 == STABLE_CYCLES is the same as cnt == STABLE_CYCLES-1; the
   // latter avoids a carry out of the counter width.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   logic            w_key_pushed;
   logic            w_key_sync;
   debounce_state_t r_state;
   logic [CNT_W-1:0] r_cnt;
   logic            r_pressed;
   logic            r_busy;

   // Normalise polarity so downstream logic always sees 1 = pushed.
   assign w_key_pushed = ACTIVE_LOW_IN ? ~key_raw : key_raw;

   // Synchronizer resets to 0, the released level in pushed polarity.
   sync_ff #(
      .N         (SYNC_STAGES),
      .RESET_VAL (1'b0)
   ) u_sync (
      .i_clk     (clk),
      .i_reset_n (reset),
      .i_d       (w_key_pushed),
      .o_q       (w_key_sync)
   );

   // Qualification FSM with stability counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= RELEASED;
         r_cnt     <= CNT_ZERO;
         r_pressed <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         unique case (r_state)
            RELEASED: begin
               if (w_key_sync) begin
                  r_state   <= PRESS_WAIT;
                  r_cnt     <= CNT_ONE;
                  r_pressed <= 1'b0;
                  r_busy    <= 1'b1;
               end else begin
                  r_state   <= RELEASED;
                  r_cnt     <= CNT_ZERO;
                  r_pressed <= 1'b0;
                  r_busy    <= 1'b0;
               end
            end

            PRESS_WAIT: begin
               if (!w_key_sync) begin
                  // Bounce: drop all progress.
                  r_state   <= RELEASED;
                  r_cnt     <= CNT_ZERO;
                  r_pressed <= 1'b0;
                  r_busy    <= 1'b0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state   <= PRESSED;
                  r_cnt     <= CNT_ZERO;
                  r_pressed <= 1'b1;
                  r_busy    <= 1'b0;
               end else begin
                  r_state   <= PRESS_WAIT;
                  r_cnt     <= r_cnt + CNT_ONE;
                  r_pressed <= 1'b0;
                  r_busy    <= 1'b1;
               end
            end

            PRESSED: begin
               if (!w_key_sync) begin
                  r_state   <= RELEASE_WAIT;
                  r_cnt     <= CNT_ONE;
                  r_pressed <= 1'b1;
                  r_busy    <= 1'b1;
               end else begin
                  r_state   <= PRESSED;
                  r_cnt     <= CNT_ZERO;
                  r_pressed <= 1'b1;
                  r_busy    <= 1'b0;
               end
            end

            RELEASE_WAIT: begin
               if (w_key_sync) begin
                  r_state   <= PRESSED;
                  r_cnt     <= CNT_ZERO;
                  r_pressed <= 1'b1;
                  r_busy    <= 1'b0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state   <= RELEASED;
                  r_cnt     <= CNT_ZERO;
                  r_pressed <= 1'b0;
                  r_busy    <= 1'b0;
               end else begin
                  r_state   <= RELEASE_WAIT;
                  r_cnt     <= r_cnt + CNT_ONE;
                  r_pressed <= 1'b1;
                  r_busy    <= 1'b1;
               end
            end

            default: begin
               r_state   <= RELEASED;
               r_cnt     <= CNT_ZERO;
               r_pressed <= 1'b0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   assign pressed = r_pressed;
   assign busy    = r_busy;

endmodule : key_debouncer
